// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared PC-mux selects, FSM state encoding and reset vector for the IF sequencer
package pipe_ctrl_pkg;
    localparam logic [2:0] PC_SEL_PC4 = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_J   = 3'd2;
    localparam logic [2:0] PC_SEL_JR  = 3'd3;
    localparam logic [2:0] PC_SEL_CP0 = 3'd4;
    localparam logic [2:0] PC_SEL_C4  = 3'd5;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        WAIT_MD  = 2'd2,
        REDIRECT = 2'd3
    } state_t;
endpackage

// File: rtl/sat_counter32.sv
// sat_counter32: 32-bit up counter with enable, synchronous clear and saturation at all-ones
//   clk   in   clock
//   clr_i in   synchronous clear (dominates enable)
//   en_i  in   count enable
//   cnt_o out  current count
module sat_counter32 (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q, cnt_d;
    always_comb cnt_d = (en_i && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= clr_i ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_pc_ctrl.sv
// pipe_pc_ctrl: IF-stage sequencer owning the PC, PC-mux select and pipeline hold/bubble/flush controls
//   clk, rst                    clock, synchronous active-high reset
//   npc_i                       next PC already chosen by the IF mux
//   exc_i, eret_i               CP0 exception / eret redirect requests
//   md_busy_i, load_use_i       multiply/divide busy, load-use hazard
//   jr_i, jump_i, branch_taken_i control transfers resolved in ID
//   pc_o                        registered PC
//   pc_select_o                 IF PC-mux select
//   pc_stall_o                  squash the fetched instruction
//   hold_o, id_ex_bubble_o      freeze PC+IF/ID, insert NOP into ID/EX
//   flush_o                     flush IF/ID and ID/EX
//   state_o, stall_cnt_o        debug state and held-cycle count
module pipe_pc_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic        md_busy_i,
    input  logic        load_use_i,
    input  logic        jr_i,
    input  logic        jump_i,
    input  logic        branch_taken_i,
    output logic [31:0] pc_o,
    output logic [2:0]  pc_select_o,
    output logic        pc_stall_o,
    output logic        hold_o,
    output logic        id_ex_bubble_o,
    output logic        flush_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o
);
    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        exc_ok, eret_ok, lu_ok;
    // REDIRECT masks sticky CP0 requests; only an exception may abort a busy multiply/divide wait
    assign exc_ok  = exc_i && state_q != REDIRECT;
    assign eret_ok = eret_i && state_q != REDIRECT && !(state_q == WAIT_MD && md_busy_i);
    // the bubble issued on entry to STALL already resolves the load-use hazard
    assign lu_ok   = load_use_i && state_q != STALL;
    always_comb begin
        pc_select_o    = PC_SEL_PC4;
        pc_stall_o     = 1'b0;
        hold_o         = 1'b0;
        id_ex_bubble_o = 1'b0;
        flush_o        = 1'b0;
        state_d        = RUN;
        if (rst) begin
            state_d = RUN;
        end else if (exc_ok || eret_ok) begin
            pc_select_o = PC_SEL_CP0;
            flush_o     = 1'b1;
            state_d     = REDIRECT;
        end else if (md_busy_i) begin
            hold_o         = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = WAIT_MD;
        end else if (lu_ok) begin
            hold_o         = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = STALL;
        end else begin
            pc_select_o = jr_i ? PC_SEL_JR : jump_i ? PC_SEL_J : branch_taken_i ? PC_SEL_BR : PC_SEL_PC4;
            pc_stall_o  = !DELAY_SLOT && pc_select_o != PC_SEL_PC4;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            if (!hold_o) pc_q <= npc_i;
            state_q <= state_d;
        end
    end
    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (hold_o),
        .cnt_o (stall_cnt_o)
    );
    assign pc_o    = pc_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// tb_pipe_pc_ctrl: scoreboard bench for pipe_pc_ctrl with directed vectors (DELAY_SLOT 0 and 1 instances)
module tb_pipe_pc_ctrl;
    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic [2:0]  sel;
        logic [4:0]  ctl;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        exc, eret, md, lu, jr, jmp, br;
    logic [31:0] pc0, pc1, cnt0, cnt1;
    logic [2:0]  sel0, sel1;
    logic        ps0, ps1, h0, h1, b0, b1, f0, f1;
    logic [1:0]  st0, st1;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          idx = 0;
    always #5 clk = ~clk;
    pipe_pc_ctrl #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .npc_i(npc), .exc_i(exc), .eret_i(eret), .md_busy_i(md),
        .load_use_i(lu), .jr_i(jr), .jump_i(jmp), .branch_taken_i(br), .pc_o(pc0),
        .pc_select_o(sel0), .pc_stall_o(ps0), .hold_o(h0), .id_ex_bubble_o(b0),
        .flush_o(f0), .state_o(st0), .stall_cnt_o(cnt0)
    );
    pipe_pc_ctrl #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .npc_i(npc), .exc_i(exc), .eret_i(eret), .md_busy_i(md),
        .load_use_i(lu), .jr_i(jr), .jump_i(jmp), .branch_taken_i(br), .pc_o(pc1),
        .pc_select_o(sel1), .pc_stall_o(ps1), .hold_o(h1), .id_ex_bubble_o(b1),
        .flush_o(f1), .state_o(st1), .stall_cnt_o(cnt1)
    );
    localparam logic [7:0] R = 8'h80, EXC = 8'h40, ERET = 8'h20, MD = 8'h10;
    localparam logic [7:0] LU = 8'h08, JR = 8'h04, J = 8'h02, BR = 8'h01;
    // ctl = {pc_stall(DS=0), pc_stall(DS=1), hold, bubble, flush}
    task automatic step(input logic [7:0] ev, input logic [31:0] n, input logic [31:0] pc,
                        input logic [1:0] st, input logic [31:0] cnt, input logic [2:0] sel,
                        input logic [4:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, exc, eret, md, lu, jr, jmp, br} = ev;
        npc = n;
        e.pc = pc; e.st = st; e.cnt = cnt; e.sel = sel; e.ctl = ctl;
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e, a;
            e = q.pop_front();
            a.pc = pc0; a.st = st0; a.cnt = cnt0; a.sel = sel0; a.ctl = {ps0, ps1, h0, b0, f0};
            checks++;
            idx++;
            if (a !== e || {sel1, h1, b1, f1, st1, pc1, cnt1} !== {sel0, h0, b0, f0, st0, pc0, cnt0}) begin
                errors++;
                $display("FAIL step%0d: got pc=%h st=%0d cnt=%0d sel=%0d ctl=%b (ds1 sel=%0d pc=%h) want pc=%h st=%0d cnt=%0d sel=%0d ctl=%b",
                         idx, a.pc, a.st, a.cnt, a.sel, a.ctl, sel1, pc1, e.pc, e.st, e.cnt, e.sel, e.ctl);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        {rst, exc, eret, md, lu, jr, jmp, br} = R;
        npc = 32'h0;
        repeat (2) @(posedge clk);
        step(R | EXC | LU, 32'h100, 32'h0,   0, 0, 0, 5'b00000);
        step(0,            32'h4,   32'h0,   0, 0, 0, 5'b00000);
        step(0,            32'h8,   32'h4,   0, 0, 0, 5'b00000);
        step(LU,           32'hC,   32'h8,   0, 0, 0, 5'b00110);
        step(LU,           32'hC,   32'h8,   1, 1, 0, 5'b00000);
        step(0,            32'h10,  32'hC,   0, 1, 0, 5'b00000);
        step(BR,           32'h40,  32'h10,  0, 1, 1, 5'b10000);
        step(JR | J | BR,  32'h50,  32'h40,  0, 1, 3, 5'b10000);
        step(J | BR,       32'h60,  32'h50,  0, 1, 2, 5'b10000);
        step(EXC | JR | LU, 32'h80, 32'h60,  0, 1, 4, 5'b00001);
        step(EXC,          32'h84,  32'h80,  3, 1, 0, 5'b00000);
        step(ERET | MD,    32'h88,  32'h84,  0, 1, 4, 5'b00001);
        step(ERET | LU,    32'h8C,  32'h88,  3, 1, 0, 5'b00110);
        step(0,            32'h8C,  32'h88,  1, 2, 0, 5'b00000);
        step(MD,           32'h90,  32'h8C,  0, 2, 0, 5'b00110);
        step(MD | ERET,    32'h90,  32'h8C,  2, 3, 0, 5'b00110);
        step(MD,           32'h90,  32'h8C,  2, 4, 0, 5'b00110);
        step(MD,           32'h90,  32'h8C,  2, 5, 0, 5'b00110);
        step(MD,           32'h90,  32'h8C,  2, 6, 0, 5'b00110);
        step(BR,           32'hA0,  32'h8C,  2, 7, 1, 5'b10000);
        step(MD,           32'hA4,  32'hA0,  0, 7, 0, 5'b00110);
        step(MD,           32'hA4,  32'hA0,  2, 8, 0, 5'b00110);
        step(MD | EXC,     32'h180, 32'hA0,  2, 9, 4, 5'b00001);
        step(MD,           32'h184, 32'h180, 3, 9, 0, 5'b00110);
        step(R | MD,       32'h184, 32'h180, 2, 10, 0, 5'b00000);
        step(0,            32'h4,   32'h0,   0, 0, 0, 5'b00000);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_pc_ctrl.md
Name: pipe_pc_ctrl

Overview:
Sequencing controller for the IF stage. It owns the architectural PC register and drives the 3-bit PC-mux select and the IF squash (pc_stall) line. It arbitrates between exception/eret, multiply/divide busy, load-use hazards and jr/jump/branch redirects, and emits hold/bubble/flush controls to the IF/ID and ID/EX registers. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DELAY_SLOT, 1, 1 = the instruction after a control transfer executes; 0 = it is squashed via pc_stall_o.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
npc_i  in  32  next PC from the IF PC mux (already selected by pc_select_o)
exc_i  in  1  exception request (CP0)
eret_i  in  1  eret decoded in ID
md_busy_i  in  1  multiply/divide unit busy
load_use_i  in  1  load-use hazard detected in ID
jr_i  in  1  jr/jalr in ID
jump_i  in  1  j/jal in ID
branch_taken_i  in  1  taken branch resolved in ID
pc_o  out  32  registered PC to IF
pc_select_o  out  3  0 pc+4, 1 branch, 2 jump, 3 rs, 4 cp0, 5 const 4 (unused)
pc_stall_o  out  1  squash the IF instruction to 32'h0
hold_o  out  1  freeze PC and IF/ID
id_ex_bubble_o  out  1  load NOP into ID/EX
flush_o  out  1  flush IF/ID and ID/EX (exception/eret)
state_o  out  2  FSM state (debug)
stall_cnt_o  out  32  cycles with hold_o=1

Behaviour:
- Reset: on a clk edge with rst=1: pc_o=RESET_PC, state=RUN, stall_cnt_o=0. While rst=1, all combinational outputs are 0.
- PC register: pc_o<=npc_i on every edge where hold_o=0. Otherwise it holds.
- States: RUN=0, STALL=1, WAIT_MD=2, REDIRECT=3.
- RUN: fixed priority, highest first:
  - exc_i or eret_i: sel=4, flush_o=1 -> REDIRECT.
  - md_busy_i: hold_o=1, id_ex_bubble_o=1 -> WAIT_MD.
  - load_use_i: hold_o=1, id_ex_bubble_o=1 -> STALL.
  - jr_i: sel=3.
  - jump_i: sel=2.
  - branch_taken_i: sel=1.
  - Otherwise sel=0.
  - For sel 1-3, pc_stall_o = (DELAY_SLOT==0). Stay in RUN.
- STALL: exactly one cycle. load_use_i is ignored because the hazard is resolved by the bubble. Every other event is evaluated as in RUN. Next state follows the RUN rules, with RUN as the default.
- WAIT_MD:
  - While md_busy_i=1: hold_o=1, id_ex_bubble_o=1.
  - exc_i aborts the wait: sel=4, flush_o=1, hold_o=0 -> REDIRECT.
  - When md_busy_i=0: hold is released in the same cycle and the RUN rules apply.
- REDIRECT: the cycle after a redirect to the handler or EPC. exc_i and eret_i are ignored, which guards against sticky requests. Other events follow the RUN rules. The state then goes to RUN.
- Simultaneous events resolve strictly by the priority above. flush_o dominates hold_o: they are never both 1.
- stall_cnt_o increments by 1 on each edge with hold_o=1 and saturates at 32'hFFFF_FFFF. It is cleared only by rst.
- Reset mid-stall or mid-wait: all state is discarded and the next cycle fetches from RESET_PC.
- Latency: pc_select_o is combinational in the same cycle as the input event. The PC update is visible on pc_o on the next edge.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - PC_SEL_* constants: PC4=0, BR=1, J=2, JR=3, CP0=4, C4=5.
  - State encodings RUN/STALL/WAIT_MD/REDIRECT.
  - Reset-vector default.
- One sub-module: sat_counter32 (enable, sync clear, saturate), used for stall_cnt_o.

Test Plan:
- Reset then 4 cycles with no events; npc_i tracks pc+4 -> pc_o = 0, 4, 8, 12; sel=0; stall_cnt_o=0.
- load_use_i=1 for 2 cycles at pc_o=8 -> 1st cycle: hold_o=1, id_ex_bubble_o=1, pc_o stays 8. 2nd cycle (STALL): load_use ignored, hold_o=0. stall_cnt_o=1.
- branch_taken_i=1, npc_i=0x40, DELAY_SLOT=0 -> sel=1, pc_stall_o=1 that cycle, next pc_o=0x40. Repeat with DELAY_SLOT=1 -> pc_stall_o=0.
- exc_i, jr_i and load_use_i all =1 together, npc_i=0x80 -> sel=4, flush_o=1, hold_o=0, pc_o=0x80, state=REDIRECT. exc_i held a 2nd cycle -> ignored, sel=0.
- md_busy_i=1 for 5 cycles -> hold_o=1 for 5 cycles, pc_o constant, stall_cnt_o=5. exc_i in the 3rd cycle -> wait aborted, sel=4, REDIRECT.
- rst pulsed during WAIT_MD -> next cycle: pc_o=RESET_PC, state_o=0, stall_cnt_o=0, all controls 0.
